// File: rtl/samp_fifo_sched_pkg.sv
// samp_pkg: shared sample type, sizes and scheduler state encoding
package samp_pkg;
  localparam int SAMP_W = 24;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [SAMP_W-1:0] I;
    logic [SAMP_W-1:0] Q;
  } samp_t;
  typedef enum logic [1:0] {IDLE, BURST, PAUSE} sched_state_e;
endpackage

// File: rtl/samp_fifo_sched_if.sv
// samp_fifo_sched_if: producer, FIFO and consumer signals of the sample scheduler
interface samp_fifo_sched_if;
  import samp_pkg::*;
  logic              PushA, PushB, StallA, StallB;
  logic [SAMP_W-1:0] SampIA, SampQA, SampIB, SampQB, SampI, SampQ;
  logic              fifo_full, fifo_empty, PushIn, fifo_PullOut;
  logic              ConsReady, OutValid, DropErr, UnderErr;
  logic [2:0]        Occ;
  modport master (
    output PushA, SampIA, SampQA, PushB, SampIB, SampQB, fifo_full, fifo_empty, ConsReady,
    input  StallA, StallB, PushIn, SampI, SampQ, fifo_PullOut, OutValid, Occ, DropErr, UnderErr
  );
  modport slave (
    input  PushA, SampIA, SampQA, PushB, SampIB, SampQB, fifo_full, fifo_empty, ConsReady,
    output StallA, StallB, PushIn, SampI, SampQ, fifo_PullOut, OutValid, Occ, DropErr, UnderErr
  );
endinterface

// File: rtl/samp_fifo_sched_rr_arb2.sv
// rr_arb2: two-request round-robin arbiter, priority passes to the other side after any grant
module rr_arb2 (
  input  logic Clk,
  input  logic Reset,
  input  logic reqA,
  input  logic reqB,
  input  logic en,
  output logic gntA,
  output logic gntB,
  output logic prio_q
);
  logic prio_d;
  assign gntA = en & reqA & (~reqB | ~prio_q);
  assign gntB = en & reqB & (~reqA | prio_q);
  // prio_q = 0 favours A; flip away from whoever was just served
  always_comb prio_d = gntA ? 1'b1 : gntB ? 1'b0 : prio_q;
  // priority register
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) prio_q <= 1'b0;
    else prio_q <= prio_d;
endmodule

// File: rtl/samp_fifo_sched.sv
// samp_fifo_sched: two-source sample holds arbitrated into a FIFO, with burst read scheduling
module samp_fifo_sched
  import samp_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input logic Clk,
  input logic Reset,
  samp_fifo_sched_if.slave bus
);
  samp_t        hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic         va_q, va_d, vb_q, vb_d;
  logic         gnt_a, gnt_b, prio_unused, load_a, load_b, pull;
  logic [2:0]   occ_q, occ_d, cnt_q, cnt_d;
  logic         drop_q, drop_d, under_q, under_d;
  sched_state_e state_q, state_d;
  rr_arb2 u_arb (
    .Clk   (Clk),
    .Reset (Reset),
    .reqA  (va_q),
    .reqB  (vb_q),
    .en    (~bus.fifo_full),
    .gntA  (gnt_a),
    .gntB  (gnt_b),
    .prio_q(prio_unused)
  );
  assign bus.StallA       = va_q & ~gnt_a;
  assign bus.StallB       = vb_q & ~gnt_b;
  assign load_a           = bus.PushA & ~bus.StallA;
  assign load_b           = bus.PushB & ~bus.StallB;
  assign bus.PushIn       = gnt_a | gnt_b;
  assign bus.SampI        = gnt_a ? hold_a_q.I : gnt_b ? hold_b_q.I : '0;
  assign bus.SampQ        = gnt_a ? hold_a_q.Q : gnt_b ? hold_b_q.Q : '0;
  assign pull             = (state_q == BURST) & bus.ConsReady & ~bus.fifo_empty;
  assign bus.fifo_PullOut = pull;
  assign bus.OutValid     = pull;
  assign bus.Occ          = occ_q;
  assign bus.DropErr      = drop_q;
  assign bus.UnderErr     = under_q;
  // holds: a grant frees the slot, a same-cycle load refills it
  always_comb begin
    hold_a_d = load_a ? '{I: bus.SampIA, Q: bus.SampQA} : hold_a_q;
    hold_b_d = load_b ? '{I: bus.SampIB, Q: bus.SampQB} : hold_b_q;
    va_d     = load_a | (va_q & ~gnt_a);
    vb_d     = load_b | (vb_q & ~gnt_b);
    drop_d   = drop_q | (bus.PushA & bus.StallA) | (bus.PushB & bus.StallB);
    occ_d    = (bus.PushIn & ~pull & occ_q != 3'(DEPTH)) ? occ_q + 3'd1 :
               (pull & ~bus.PushIn & occ_q != 3'd0) ? occ_q - 3'd1 : occ_q;
  end
  // burst scheduler: start on a full burst worth of data, pause while the consumer stalls
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    under_d = under_q;
    case (state_q)
      IDLE:  if (occ_q >= 3'(BURST_LEN) && bus.ConsReady) state_d = BURST;
      BURST:
        if (!bus.ConsReady) state_d = PAUSE;
        else if (bus.fifo_empty) under_d = 1'b1;
        else if (cnt_q == 3'(BURST_LEN - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else cnt_d = cnt_q + 3'd1;
      PAUSE: if (bus.ConsReady) state_d = BURST;
      default: state_d = IDLE;
    endcase
  end
  // state registers
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      hold_a_q <= '0;
      hold_b_q <= '0;
      va_q     <= 1'b0;
      vb_q     <= 1'b0;
      occ_q    <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      under_q  <= 1'b0;
      state_q  <= IDLE;
    end else begin
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      va_q     <= va_d;
      vb_q     <= vb_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      under_q  <= under_d;
      state_q  <= state_d;
    end
endmodule

// File: tb/tb_samp_fifo_sched.sv
// tb_samp_fifo_sched: directed plus random stimulus checked against a behavioural scheduler model
module tb_samp_fifo_sched;
  import samp_pkg::*;
  localparam int BL = 4;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int n_vec = 0, n_err = 0;
  bit hv[2];
  logic [47:0] hd[2];
  int prio, occ, ph, cnt;
  bit drop, under, ff, fe;
  logic [47:0] fq[$];
  always #5 Clk = ~Clk;
  samp_fifo_sched_if bus ();
  samp_fifo_sched #(.BURST_LEN(BL)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hv = '{0, 0};
    hd = '{48'd0, 48'd0};
    prio = 0; occ = 0; ph = 0; cnt = 0; drop = 0; under = 0; ff = 0; fe = 0;
    fq.delete();
  endtask

  task automatic idle_inputs();
    bus.PushA = 0; bus.SampIA = 0; bus.SampQA = 0;
    bus.PushB = 0; bus.SampIB = 0; bus.SampQB = 0;
    bus.ConsReady = 0; bus.fifo_full = 0; bus.fifo_empty = 1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1;
    idle_inputs();
    model_reset();
    @(negedge Clk);
    Reset = 0;
  endtask

  task automatic step(input bit pa, input logic [23:0] ia, input bit pb, input logic [23:0] ib, input bit cr);
    int g;
    bit full, empty, pull, sa, sb;
    logic [47:0] ed;
    full  = fq.size() == DEPTH || ff;
    empty = fq.size() == 0 || fe;
    bus.PushA = pa; bus.SampIA = ia; bus.SampQA = -ia;
    bus.PushB = pb; bus.SampIB = ib; bus.SampQB = -ib;
    bus.fifo_full = full; bus.fifo_empty = empty; bus.ConsReady = cr;
    #1;
    g = full ? -1 : (hv[0] && hv[1]) ? prio : hv[0] ? 0 : hv[1] ? 1 : -1;
    ed = 48'd0;
    if (g >= 0) ed = hd[g];
    sa = hv[0] && g != 0;
    sb = hv[1] && g != 1;
    pull = ph == 1 && cr && !empty;
    check("PushIn", bus.PushIn, g >= 0);
    check("SampI", bus.SampI, ed[47:24]);
    check("SampQ", bus.SampQ, ed[23:0]);
    check("StallA", bus.StallA, sa);
    check("StallB", bus.StallB, sb);
    check("PullOut", bus.fifo_PullOut, pull);
    check("OutValid", bus.OutValid, pull);
    check("Occ", bus.Occ, occ);
    check("DropErr", bus.DropErr, drop);
    check("UnderErr", bus.UnderErr, under);
    @(posedge Clk);
    if (pull) void'(fq.pop_front());
    if (g >= 0) fq.push_back(ed);
    if ((pa && sa) || (pb && sb)) drop = 1;
    if (g >= 0) begin hv[g] = 0; prio = 1 - g; end
    if (pa && !sa) begin hv[0] = 1; hd[0] = {ia, -ia}; end
    if (pb && !sb) begin hv[1] = 1; hd[1] = {ib, -ib}; end
    occ = occ + (g >= 0) - pull;
    if (occ > DEPTH) occ = DEPTH;
    if (occ < 0) occ = 0;
    case (ph)
      0: if (occ - (g >= 0) + pull >= BL && cr) ph = 1;
      1: if (!cr) ph = 2;
         else if (empty) under = 1;
         else if (++cnt == BL) begin cnt = 0; ph = 0; end
      default: if (cr) ph = 1;
    endcase
    @(negedge Clk);
  endtask

  task automatic fill_a4();
    for (int i = 0; i < 4; i++) step(1, 24'(i + 1), 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12 Reset = 0;
    @(negedge Clk);
    step(0, 0, 0, 0, 0);
    // A-only stream, then a clean burst
    fill_a4();
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1);
    // simultaneous first pushes: A wins, B stalls one cycle
    do_reset();
    step(1, 10, 1, 20, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    // FIFO full blocks both holds, push while stalled drops, release alternates
    do_reset();
    ff = 1;
    step(1, 5, 1, 6, 0);
    step(0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    ff = 0;
    step(1, 8, 1, 9, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    // burst with a three-cycle consumer pause after two pulls
    do_reset();
    fill_a4();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    // forced empty during burst
    do_reset();
    fill_a4();
    step(0, 0, 0, 0, 1);
    fe = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    fe = 0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    // asynchronous reset mid-burst after pull 2
    do_reset();
    fill_a4();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    bus.PushA = 1; bus.SampIA = 24'h55;
    #2 Reset = 1;
    #1;
    check("rst_PushIn", bus.PushIn, 0);
    check("rst_SampI", bus.SampI, 0);
    check("rst_SampQ", bus.SampQ, 0);
    check("rst_StallA", bus.StallA, 0);
    check("rst_StallB", bus.StallB, 0);
    check("rst_PullOut", bus.fifo_PullOut, 0);
    check("rst_OutValid", bus.OutValid, 0);
    check("rst_Occ", bus.Occ, 0);
    check("rst_DropErr", bus.DropErr, 0);
    check("rst_UnderErr", bus.UnderErr, 0);
    idle_inputs();
    model_reset();
    @(negedge Clk);
    Reset = 0;
    step(1, 30, 1, 40, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ff = $urandom_range(0, 9) == 0;
      step(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 1)), 24'($urandom),
           $urandom_range(0, 3) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
